// File: rtl/run_sequencer_if.sv
// run_sequencer_if -- signal bundle between the run sequencer and its surroundings.
//
// Carries three groups of signals:
//   batch control  : go (request), busy, batch_done
//   processor side : proc_reset, start, ack, prog_sel
//   report channel : run_cycles, run_timeout, result_valid, result_ready
//
// Modports:
//   master : the run_sequencer itself (drives proc_reset/start/report, samples go/ack/ready)
//   slave  : whatever drives go, ack and result_ready (processor wrapper, host, bench)
interface run_sequencer_if #(
  parameter int PROG_W = 2
);
  logic              go;
  logic              busy;
  logic              batch_done;
  logic              proc_reset;
  logic              start;
  logic              ack;
  logic [PROG_W-1:0] prog_sel;
  logic [15:0]       run_cycles;
  logic              run_timeout;
  logic              result_valid;
  logic              result_ready;

  modport master (
    input  go, ack, result_ready,
    output busy, batch_done, proc_reset, start, prog_sel,
           run_cycles, run_timeout, result_valid
  );

  modport slave (
    output go, ack, result_ready,
    input  busy, batch_done, proc_reset, start, prog_sel,
           run_cycles, run_timeout, result_valid
  );
endinterface

// File: rtl/run_sequencer.sv
// run_sequencer -- host-side initiator for the processor start/ack handshake.
//
// Runs NUM_PROGS programs back to back. For each program it holds proc_reset
// for RST_CYCLES cycles, then start for START_CYCLES cycles, then counts RUN
// cycles until ack (or until TIMEOUT cycles elapse) and offers the cycle count
// on a valid/ready report channel. After the last report is accepted it pulses
// batch_done for one cycle and returns to IDLE.
//
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous, active-low reset
//   bus    run_sequencer_if.master:
//            go (in), ack (in), result_ready (in)
//            busy, batch_done, proc_reset, start, prog_sel,
//            run_cycles, run_timeout, result_valid (out, all registered)
module run_sequencer #(
  parameter int NUM_PROGS    = 3,
  parameter int PROG_W       = 2,
  parameter int RST_CYCLES   = 2,
  parameter int START_CYCLES = 4,
  parameter int TIMEOUT      = 4096
) (
  input  logic            clk,
  input  logic            reset,
  run_sequencer_if.master bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PRST = 3'd1;
  localparam logic [2:0] STRT = 3'd2;
  localparam logic [2:0] RUN  = 3'd3;
  localparam logic [2:0] RPT  = 3'd4;

  localparam logic [15:0]       RST_LAST   = 16'(RST_CYCLES - 1);
  localparam logic [15:0]       START_LAST = 16'(START_CYCLES - 1);
  localparam logic [15:0]       TO_LAST    = 16'(TIMEOUT - 1);
  localparam logic [15:0]       TO_VALUE   = 16'(TIMEOUT);
  localparam logic [PROG_W-1:0] PROG_LAST  = PROG_W'(NUM_PROGS - 1);

  logic [2:0]        state;
  logic [15:0]       counter;
  logic [PROG_W-1:0] prog_sel_q;
  logic [15:0]       run_cycles_q;
  logic              run_timeout_q;
  logic              busy_q;
  logic              proc_reset_q;
  logic              start_q;
  logic              result_valid_q;
  logic              batch_done_q;

  // NOTE: every output is a flop set on the transition into the state that
  // owns it, so go/ack/result_ready never reach an output combinationally.
  assign bus.busy         = busy_q;
  assign bus.batch_done   = batch_done_q;
  assign bus.proc_reset   = proc_reset_q;
  assign bus.start        = start_q;
  assign bus.prog_sel     = prog_sel_q;
  assign bus.run_cycles   = run_cycles_q;
  assign bus.run_timeout  = run_timeout_q;
  assign bus.result_valid = result_valid_q;

  // NOTE: non-blocking assignments throughout, so every branch reads the
  // pre-edge value of counter/prog_sel regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      counter        <= '0;
      prog_sel_q     <= '0;
      run_cycles_q   <= '0;
      run_timeout_q  <= 1'b0;
      busy_q         <= 1'b0;
      proc_reset_q   <= 1'b0;
      start_q        <= 1'b0;
      result_valid_q <= 1'b0;
      batch_done_q   <= 1'b0;
    end else begin
      batch_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.go) begin
            state        <= PRST;
            busy_q       <= 1'b1;
            proc_reset_q <= 1'b1;
            prog_sel_q   <= '0;
            counter      <= '0;
          end
        end
        // ack is deliberately ignored while the processor is held in reset
        // or being started.
        PRST: begin
          if (counter == RST_LAST) begin
            state        <= STRT;
            counter      <= '0;
            proc_reset_q <= 1'b0;
            start_q      <= 1'b1;
          end else begin
            counter <= counter + 16'd1;
          end
        end
        STRT: begin
          if (counter == START_LAST) begin
            state   <= RUN;
            counter <= '0;
            start_q <= 1'b0;
          end else begin
            counter <= counter + 16'd1;
          end
        end
        // counter equals the number of completed ack-free RUN cycles; ack is
        // tested first so it wins over a simultaneous timeout.
        RUN: begin
          if (bus.ack) begin
            state          <= RPT;
            run_cycles_q   <= counter;
            run_timeout_q  <= 1'b0;
            result_valid_q <= 1'b1;
          end else if (counter == TO_LAST) begin
            state          <= RPT;
            run_cycles_q   <= TO_VALUE;
            run_timeout_q  <= 1'b1;
            result_valid_q <= 1'b1;
          end else begin
            counter <= counter + 16'd1;
          end
        end
        RPT: begin
          if (bus.result_ready) begin
            result_valid_q <= 1'b0;
            counter        <= '0;
            if (prog_sel_q == PROG_LAST) begin
              state        <= IDLE;
              busy_q       <= 1'b0;
              batch_done_q <= 1'b1;
            end else begin
              state        <= PRST;
              prog_sel_q   <= prog_sel_q + PROG_W'(1);
              proc_reset_q <= 1'b1;
            end
          end
        end
        default: begin
          state          <= IDLE;
          counter        <= '0;
          busy_q         <= 1'b0;
          proc_reset_q   <= 1'b0;
          start_q        <= 1'b0;
          result_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
